rr_arb8: RTL and testbench

Round-robin arbiter that shares one resource among up to eight requesters and reports the winner both one-hot and as a binary index. The 3-bit index uses the same encoding as the team's 8-to-3 encoder. It sits in front of a shared datapath resource, such as a bus port or functional unit, and sequences ownership. It adds grant hold, release and a hold-timeout watchdog so no requester can starve the others.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 42 ++++
 rtl/rr_arb8.sv | 120 ++++++++++++
 tb/tb_rr_arb8.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// default sizing parameters.
package arb_pkg;

  localparam int ARB_N       = 8;
  localparam int ARB_IDXW    = 3;
  localparam int ARB_MAXHOLD = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: first set request bit scanning
// upward from last+1, wrapping, so requester `last` has the lowest priority.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = ARB_N,
  parameter int IDXW = ARB_IDXW
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic            found,
  output logic [IDXW-1:0] win_idx
);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] src;
  logic [IDXW-1:0] ofs;

  // N is a power of two, so modulo-N wraps for free in IDXW-bit arithmetic.
  always_comb begin
    rot = '0;
    src = '0;
    for (int i = 0; i < N; i++) begin
      src    = IDXW'(i) + last + IDXW'(1);
      rot[i] = req[src];
    end
  end

  always_comb begin
    found = 1'b0;
    ofs   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        ofs   = IDXW'(i);
      end
    end
  end

  assign win_idx = ofs + last + IDXW'(1);

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter with registered one-hot/binary grant, grant hold until
// done or withdraw, and a hold-timeout watchdog.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int N       = ARB_N,
  parameter int IDXW    = ARB_IDXW,
  parameter int MAXHOLD = ARB_MAXHOLD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int CW = $clog2(MAXHOLD);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic            start_grant;
  logic            hold_max;
  logic            owner_req;
  logic            rel;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .found   (pick_found),
    .win_idx (pick_idx)
  );

  assign start_grant = en && pick_found;
  assign hold_max    = (cnt_q == CW'(MAXHOLD - 1));
  assign owner_req   = req[idx_q];
  assign rel         = done || !owner_req || hold_max;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (start_grant) begin
          state_d = ARB_GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          idx_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (rel) begin
          // Watchdog only claims the release when done and withdraw did not.
          timeout_d = hold_max && !done && owner_req;
          if (start_grant) begin
            gnt_d  = {{(N-1){1'b0}}, 1'b1} << pick_idx;
            idx_d  = pick_idx;
            last_d = pick_idx;
            cnt_d  = '0;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= IDXW'(N - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == ARB_GRANT);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: reset, single grant, rotation, wrap priority,
// watchdog timeout, withdraw, en gating and mid-grant reset.
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  logic [12:0] obs;
  logic [12:0] exp_v;

  rr_arb8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {gnt, gnt_idx, gnt_valid, timeout};

  // Expected {gnt, gnt_idx, gnt_valid, timeout} for a given owner state.
  function automatic logic [12:0] mk(input logic valid, input logic [2:0] idx,
                                     input logic to);
    logic [7:0] g;
    g = valid ? (8'h01 << idx) : 8'h00;
    return {g, valid ? idx : 3'd0, valid, to};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 8'hFF; done = 1'b0;
    tick();
    exp_v = mk(1'b0, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
    end
    tick();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, exp_v);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; req = 8'h01;
    tick();
    exp_v = mk(1'b1, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_grant: got %h expected %h", obs, exp_v);
    end
    done = 1'b1; req = 8'h00;
    tick();
    exp_v = mk(1'b0, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_release: got %h expected %h", obs, exp_v);
    end
    done = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] e_idx;
    do_reset();
    en = 1'b1; req = 8'hFF; done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      e_idx = 3'(k);
      exp_v = mk(1'b1, e_idx, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rotate_step%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1; req = 8'h04;
    tick();
    exp_v = mk(1'b1, 3'd2, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_setup: got %h expected %h", obs, exp_v);
    end
    req = 8'h05; done = 1'b1;
    tick();
    exp_v = mk(1'b1, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_from2: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = mk(1'b1, 3'd2, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_from0: got %h expected %h", obs, exp_v);
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1; req = 8'h10;
    exp_v = mk(1'b1, 3'd4, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL timeout_hold_c%0d: got %h expected %h", c, obs, exp_v);
      end
      if (c == 8) en = 1'b0;
    end
    tick();
    exp_v = mk(1'b0, 3'd0, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL timeout_pulse: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = mk(1'b0, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL timeout_one_cycle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_done_vs_timeout();
    do_reset();
    en = 1'b1; req = 8'h10;
    tick();
    en = 1'b0;
    for (int c = 2; c <= 16; c++) tick();
    exp_v = mk(1'b1, 3'd4, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL coincide_last_cycle: got %h expected %h", obs, exp_v);
    end
    done = 1'b1;
    tick();
    exp_v = mk(1'b0, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL coincide_no_timeout: got %h expected %h", obs, exp_v);
    end
    done = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    en = 1'b1; req = 8'h08;
    tick();
    exp_v = mk(1'b1, 3'd3, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL withdraw_setup: got %h expected %h", obs, exp_v);
    end
    req = 8'h40;
    tick();
    exp_v = mk(1'b1, 3'd6, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL withdraw_next: got %h expected %h", obs, exp_v);
    end
    en = 1'b0;
    tick();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL en_low_hold: got %h expected %h", obs, exp_v);
    end
    done = 1'b1;
    tick();
    exp_v = mk(1'b0, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL en_low_release: got %h expected %h", obs, exp_v);
    end
    done = 1'b0;
    tick();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL en_low_stay_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    en = 1'b1; req = 8'h20;
    tick();
    exp_v = mk(1'b1, 3'd5, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midreset_setup: got %h expected %h", obs, exp_v);
    end
    rst_n = 1'b0;
    tick();
    exp_v = mk(1'b0, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midreset_drop: got %h expected %h", obs, exp_v);
    end
    rst_n = 1'b1; req = 8'hFF;
    tick();
    exp_v = mk(1'b1, 3'd0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midreset_restart: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_done_vs_timeout();
    test_withdraw();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
